bcd_subtractor_4digits_serial: RTL



---
 rtl/bcd_subtractor_4digits_serial_if.sv | 28 ++
 rtl/bcd_subtractor_4digits_serial.sv | 123 ++++++++++++
 2 files changed

// File: rtl/bcd_subtractor_4digits_serial_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_subtractor_4digits_serial_if                                          |
// | Start/done handshake and operand/result bus of the serial BCD subtractor. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface bcd_subtractor_4digits_serial_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        invalid;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, invalid
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, invalid
    );
endinterface
`default_nettype wire

// File: rtl/bcd_subtractor_4digits_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_subtractor_4digits_serial                                            |
// | Digit-serial A - B - bin on 4 packed BCD digits, LSD first, 1 digit/clk. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bcd_subtractor_4digits_serial (
    input  wire logic                       clock,
    input  wire logic                       reset_n,
    bcd_subtractor_4digits_serial_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_borrow;
    logic        r_inv;
    logic [15:0] r_work;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_diff;
    logic        r_bout;
    logic        r_invalid;

    logic [7:0]  w_bad;
    logic        w_inv_in;
    logic [3:0]  w_a_dig;
    logic [3:0]  w_b_dig;
    logic [4:0]  w_t;
    logic        w_borrow;
    logic [3:0]  w_digit;

    // Non-decimal nibble detection on the operands presented at acceptance
    for (genvar i = 0; i < 4; i++) begin : g_digit_check
        assign w_bad[i]     = (bus.a[4*i +: 4] > 4'd9);
        assign w_bad[i + 4] = (bus.b[4*i +: 4] > 4'd9);
    end

    assign w_inv_in = |w_bad;

    assign w_a_dig  = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_dig  = r_b[{r_idx, 2'b00} +: 4];
    assign w_t      = {1'b0, w_a_dig} - {1'b0, w_b_dig} - {4'b0000, r_borrow};
    // A negative 5-bit result wraps; adding ten to its low nibble gives the digit mod 16
    assign w_borrow = w_t[4];
    assign w_digit  = w_borrow ? (w_t[3:0] + 4'd10) : w_t[3:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= 2'd0;
            r_a       <= 16'h0000;
            r_b       <= 16'h0000;
            r_borrow  <= 1'b0;
            r_inv     <= 1'b0;
            r_work    <= 16'h0000;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_diff    <= 16'h0000;
            r_bout    <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_borrow <= bus.bin;
                        r_inv    <= w_inv_in;
                        r_idx    <= 2'd0;
                        r_work   <= 16'h0000;
                        r_busy   <= 1'b1;
                        r_state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_work[{r_idx, 2'b00} +: 4] <= w_digit;
                    r_borrow <= w_borrow;
                    r_idx    <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        if (r_inv) begin
                            r_diff    <= 16'h0000;
                            r_bout    <= 1'b0;
                            r_invalid <= 1'b1;
                        end else begin
                            // Top digit is still in flight, so merge it directly
                            r_diff    <= {w_digit, r_work[11:0]};
                            r_bout    <= w_borrow;
                            r_invalid <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.diff    = r_diff;
    assign bus.bout    = r_bout;
    assign bus.invalid = r_invalid;

endmodule
`default_nettype wire
